// File: rtl/qsort_arb.sv
// rtl/qsort_arb.sv - two-requester round-robin front end for a streaming sort engine
// Optional SORT watchdog enabled by defining QSORT_ARB_TIMEOUT_EN.
module qsort_arb #(
    parameter int pDATA_WIDTH = 32,
    parameter int pN          = 10
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic [1:0]               req,
    output logic [1:0]               gnt,
    output logic [1:0]               job_done,
    input  logic [1:0]               s_tvalid,
    output logic [1:0]               s_tready,
    input  logic [2*pDATA_WIDTH-1:0] s_tdata,
    output logic [1:0]               m_tvalid,
    input  logic [1:0]               m_tready,
    output logic [2*pDATA_WIDTH-1:0] m_tdata,
    output logic                     eng_start,
    output logic                     eng_clr,
    output logic                     eng_ss_tvalid,
    output logic [pDATA_WIDTH-1:0]   eng_ss_tdata,
    input  logic                     eng_ss_tready,
    input  logic                     eng_sm_tvalid,
    input  logic [pDATA_WIDTH-1:0]   eng_sm_tdata,
    output logic                     eng_sm_tready,
    input  logic                     eng_done,
    output logic [1:0]               err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SORT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;

    localparam logic [3:0] LAST_WORD = 4'(pN - 1);

    logic [2:0] state;
    logic [3:0] word_cnt;
    logic       last_gnt;
    logic       clr_hold;
    logic       g;
    logic       winner;
    logic       load_fire;
    logic       drain_fire;
    logic [pDATA_WIDTH-1:0] s_word;

    assign g = gnt[1];
    assign s_word = g ? s_tdata[2*pDATA_WIDTH-1:pDATA_WIDTH] : s_tdata[pDATA_WIDTH-1:0];

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end
    end

    assign load_fire  = (state == LOAD)  && s_tvalid[g] && eng_ss_tready;
    assign drain_fire = (state == DRAIN) && eng_sm_tvalid && m_tready[g];

`ifdef QSORT_ARB_TIMEOUT_EN
    logic [7:0] wdog;
    logic       wdog_expire;

    assign wdog_expire = (state == SORT) && !eng_done && (wdog == 8'd254);

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            wdog <= 8'd0;
            err  <= 2'b00;
        end else if (state != SORT) begin
            wdog <= 8'd0;
        end else if (!eng_done) begin
            wdog <= wdog + 8'd1;
            if (wdog_expire) begin
                err[g] <= 1'b1;
            end
        end
    end
`else
    logic wdog_expire;
    assign wdog_expire = 1'b0;
    assign err         = 2'b00;
`endif

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            word_cnt <= 4'd0;
            last_gnt <= 1'b1;
            clr_hold <= 1'b1;
        end else begin
            clr_hold <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt   <= {winner, ~winner};
                        state <= START;
                    end
                end
                START: begin
                    word_cnt <= 4'd0;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (load_fire) begin
                        word_cnt <= word_cnt + 4'd1;
                        if (word_cnt == LAST_WORD) begin
                            state <= SORT;
                        end
                    end
                end
                SORT: begin
                    if (eng_done) begin
                        word_cnt <= 4'd0;
                        state    <= DRAIN;
                    end else if (wdog_expire) begin
                        state <= CLEAR;
                    end
                end
                DRAIN: begin
                    if (drain_fire) begin
                        word_cnt <= word_cnt + 4'd1;
                        if (word_cnt == LAST_WORD) begin
                            state <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    gnt      <= 2'b00;
                    last_gnt <= g;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream muxing; everything is gated by state so reset forces all of it low.
    always_comb begin
        s_tready      = 2'b00;
        m_tvalid      = 2'b00;
        m_tdata       = '0;
        eng_ss_tvalid = 1'b0;
        eng_ss_tdata  = '0;
        eng_sm_tready = 1'b0;
        if (state == LOAD) begin
            eng_ss_tvalid = s_tvalid[g];
            eng_ss_tdata  = s_word;
            s_tready[g]   = eng_ss_tready;
        end
        if (state == DRAIN) begin
            m_tvalid[g]   = eng_sm_tvalid;
            eng_sm_tready = m_tready[g];
            if (g) begin
                m_tdata[2*pDATA_WIDTH-1:pDATA_WIDTH] = eng_sm_tdata;
            end else begin
                m_tdata[pDATA_WIDTH-1:0] = eng_sm_tdata;
            end
        end
    end

    assign eng_start = (state == START);
    assign eng_clr   = clr_hold || (state == CLEAR);
    assign job_done  = (state == CLEAR) ? gnt : 2'b00;

endmodule

// File: tb/tb_qsort_arb.sv
// tb/tb_qsort_arb.sv - table-driven and randomized bench for qsort_arb with a behavioural sort engine
`timescale 1ns/1ps
module tb_qsort_arb;

    localparam int W = 32;
    localparam int N = 10;

    logic           axis_clk = 1'b0;
    logic           axis_rst;
    logic [1:0]     req, gnt, job_done, s_tvalid, s_tready, m_tvalid, m_tready, err;
    logic [2*W-1:0] s_tdata, m_tdata;
    logic           eng_start, eng_clr, eng_ss_tvalid, eng_ss_tready;
    logic           eng_sm_tvalid, eng_sm_tready, eng_done;
    logic [W-1:0]   eng_ss_tdata, eng_sm_tdata;

    qsort_arb #(.pDATA_WIDTH(W), .pN(N)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .req(req), .gnt(gnt), .job_done(job_done),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .eng_start(eng_start), .eng_clr(eng_clr),
        .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tdata(eng_ss_tdata), .eng_ss_tready(eng_ss_tready),
        .eng_sm_tvalid(eng_sm_tvalid), .eng_sm_tdata(eng_sm_tdata), .eng_sm_tready(eng_sm_tready),
        .eng_done(eng_done), .err(err)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [1:0] rq;
        logic [1:0] exp_gnt;
        int         vm;
        int         rm;
        bit         drop;
        bit         fixed;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] src_q0[$], src_q1[$];
    logic [W-1:0] eng_in[$], eng_sorted[$];
    logic [W-1:0] got_q[$];
    int           eng_phase, eng_delay;
    bit           eng_hang;
    int           vmode, rmode;
    logic         tog;

    logic [1:0]   s_fire_s, m_fire_s, gnt_s, err_s, done_seen, gnt_seen;
    logic         ss_fire_s, sm_fire_s, clr_s, mv_any;
    logic [W-1:0] ss_data_s;
    int           n_start, n_done, n_clr, load_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_outs"}, {gnt, job_done, s_tready, m_tvalid, eng_start, eng_ss_tvalid,
                                 eng_sm_tready, (m_tdata != 0), (eng_ss_tdata != 0)}, 64'd0);
        check({name, "_clr"}, eng_clr, 1);
    endtask

    task automatic drive_inputs();
        s_tvalid[0] = (src_q0.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
        s_tvalid[1] = (src_q1.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
        s_tdata = '0;
        if (src_q0.size() > 0) s_tdata[W-1:0] = src_q0[0];
        if (src_q1.size() > 0) s_tdata[2*W-1:W] = src_q1[0];
        eng_ss_tready = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (rmode)
            0: m_tready = 2'b11;
            1: m_tready = 2'($urandom_range(0, 3));
            default: begin
                tog = ~tog;
                m_tready = {tog, tog};
            end
        endcase
        eng_done      = (eng_phase == 2);
        eng_sm_tvalid = (eng_phase == 2);
        eng_sm_tdata  = 32'hdead_beef;
        if (eng_sorted.size() > 0) eng_sm_tdata = eng_sorted[0];
    endtask

    // One clock: observe at the falling edge, advance models just after the rising edge.
    task automatic cycle();
        logic ok;
        @(negedge axis_clk);
        s_fire_s  = s_tvalid & s_tready;
        m_fire_s  = m_tvalid & m_tready;
        ss_fire_s = eng_ss_tvalid && eng_ss_tready;
        ss_data_s = eng_ss_tdata;
        sm_fire_s = eng_sm_tvalid && eng_sm_tready;
        clr_s     = eng_clr;
        gnt_s     = gnt;
        err_s     = err;
        ok = (gnt != 2'b11);
        if (!gnt[0]) ok = ok && !s_tready[0] && !m_tvalid[0] && (m_tdata[W-1:0] == 0);
        if (!gnt[1]) ok = ok && !s_tready[1] && !m_tvalid[1] && (m_tdata[2*W-1:W] == 0);
`ifndef QSORT_ARB_TIMEOUT_EN
        ok = ok && (err == 2'b00);
`endif
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL invariant: gnt=%b s_tready=%b m_tvalid=%b m_tdata=%h err=%b required idle streams quiet",
                     gnt, s_tready, m_tvalid, m_tdata, err);
        end
        if (eng_start) n_start++;
        if (eng_clr && !axis_rst) n_clr++;
        if (job_done != 2'b00) begin
            n_done++;
            done_seen = job_done;
        end
        if (gnt != 2'b00 && gnt_seen == 2'b00) gnt_seen = gnt;
        if (m_tvalid != 2'b00) mv_any = 1'b1;
        if (m_fire_s[0]) got_q.push_back(m_tdata[W-1:0]);
        if (m_fire_s[1]) got_q.push_back(m_tdata[2*W-1:W]);
        if (s_fire_s != 2'b00) load_cnt++;
        @(posedge axis_clk);
        #1;
        if (clr_s) begin
            eng_in.delete();
            eng_sorted.delete();
            eng_phase = 0;
        end else begin
            if (ss_fire_s) begin
                eng_in.push_back(ss_data_s);
                if (eng_in.size() == N) begin
                    eng_sorted = eng_in;
                    eng_sorted.sort();
                    eng_phase = 1;
                    eng_delay = $urandom_range(0, 4);
                end
            end else if (eng_phase == 1 && !eng_hang) begin
                if (eng_delay == 0) eng_phase = 2;
                else eng_delay--;
            end
            if (sm_fire_s && eng_sorted.size() > 0) void'(eng_sorted.pop_front());
        end
        if (s_fire_s[0] && src_q0.size() > 0) void'(src_q0.pop_front());
        if (s_fire_s[1] && src_q1.size() > 0) void'(src_q1.pop_front());
        drive_inputs();
    endtask

    task automatic start_job(input logic [1:0] rq, input logic [1:0] exp_g, input int vm, input int rm,
                             input bit fixed, output logic [W-1:0] exp_q[$]);
        logic [W-1:0] w0, w1;
        vmode = vm;
        rmode = rm;
        src_q0.delete();
        src_q1.delete();
        exp_q.delete();
        got_q.delete();
        n_start = 0; n_done = 0; n_clr = 0; load_cnt = 0;
        done_seen = 2'b00; gnt_seen = 2'b00; mv_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            w0 = fixed ? W'(N - 1 - i) : W'($urandom);
            w1 = W'($urandom);
            src_q0.push_back(w0);
            src_q1.push_back(w1);
            exp_q.push_back(exp_g[1] ? w1 : w0);
        end
        exp_q.sort();
        req = rq;
        drive_inputs();
    endtask

    task automatic run_job(input logic [1:0] rq, input logic [1:0] exp_g, input int vm, input int rm,
                           input bit drop, input bit fixed, input logic [1:0] next_rq);
        logic [W-1:0] exp_q[$];
        int cyc;
        start_job(rq, exp_g, vm, rm, fixed, exp_q);
        cyc = 0;
        while (n_done == 0 && cyc < 3000) begin
            cycle();
            cyc++;
            if (drop && load_cnt > 0) req = 2'b00;
        end
        check("job_finished", (cyc < 3000), 1);
        req = next_rq;
        cycle();
        check("gnt_after_clear", gnt_s, 2'b00);
        check("gnt", gnt_seen, exp_g);
        check("job_done_bit", done_seen, exp_g);
        check("job_done_count", n_done, 1);
        check("eng_start_count", n_start, 1);
        check("eng_clr_count", n_clr, 1);
        check("out_count", got_q.size(), N);
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            check($sformatf("out_word%0d", i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        logic [W-1:0] exp_q[$];
        int cyc;
        vecs[0] = '{rq: 2'b11, exp_gnt: 2'b01, vm: 0, rm: 0, drop: 0, fixed: 0};
        vecs[1] = '{rq: 2'b11, exp_gnt: 2'b10, vm: 0, rm: 0, drop: 0, fixed: 0};
        vecs[2] = '{rq: 2'b01, exp_gnt: 2'b01, vm: 0, rm: 0, drop: 0, fixed: 1};
        vecs[3] = '{rq: 2'b01, exp_gnt: 2'b01, vm: 0, rm: 2, drop: 0, fixed: 0};
        vecs[4] = '{rq: 2'b10, exp_gnt: 2'b10, vm: 1, rm: 1, drop: 1, fixed: 0};
        vecs[5] = '{rq: 2'b11, exp_gnt: 2'b01, vm: 1, rm: 1, drop: 0, fixed: 0};
        vecs[6] = '{rq: 2'b11, exp_gnt: 2'b10, vm: 1, rm: 2, drop: 0, fixed: 0};
        vecs[7] = '{rq: 2'b10, exp_gnt: 2'b10, vm: 1, rm: 1, drop: 0, fixed: 0};

        axis_rst = 1'b1;
        req = 2'b00; s_tvalid = 2'b00; s_tdata = '0; m_tready = 2'b00;
        eng_ss_tready = 1'b0; eng_sm_tvalid = 1'b0; eng_sm_tdata = '0; eng_done = 1'b0;
        eng_phase = 0; eng_delay = 0; eng_hang = 1'b0; vmode = 0; rmode = 0; tog = 1'b0;
        @(posedge axis_clk);
        #1;
        check_reset_outputs("reset");
        check("reset_err", err, 2'b00);
        @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;
        drive_inputs();
        cycle();
        check("clr_after_reset", eng_clr, 0);

        for (int i = 0; i < NV; i++) begin
            run_job(vecs[i].rq, vecs[i].exp_gnt, vecs[i].vm, vecs[i].rm, vecs[i].drop, vecs[i].fixed,
                    (i < NV - 1) ? vecs[i + 1].rq : 2'b00);
        end
        req = 2'b00;

        // Reset in the middle of a load, then the pointer must favour requester 0 again.
        start_job(2'b10, 2'b10, 0, 0, 0, exp_q);
        cyc = 0;
        while (load_cnt < 5 && cyc < 200) begin
            cycle();
            cyc++;
        end
        check("midjob_loaded", load_cnt, 5);
        axis_rst = 1'b1;
        #1;
        check_reset_outputs("midjob_reset");
        req = 2'b00;
        src_q0.delete();
        src_q1.delete();
        cycle();
        check_reset_outputs("midjob_reset_held");
        axis_rst = 1'b0;
        #1;
        check("clr_until_edge", eng_clr, 1);
        drive_inputs();
        cycle();
        check("clr_released", eng_clr, 0);
        run_job(2'b11, 2'b01, 0, 0, 0, 0, 2'b01);
        run_job(2'b01, 2'b01, 1, 1, 0, 0, 2'b00);

`ifdef QSORT_ARB_TIMEOUT_EN
        begin
            int sort_cyc;
            bit err_early;
            eng_hang = 1'b1;
            start_job(2'b01, 2'b01, 0, 0, 0, exp_q);
            cyc = 0;
            while (load_cnt < N && cyc < 200) begin
                cycle();
                cyc++;
                if (load_cnt > 0) req = 2'b00;
            end
            check("wdog_loaded", load_cnt, N);
            sort_cyc = 0;
            err_early = 1'b0;
            while (n_done == 0 && sort_cyc < 400) begin
                cycle();
                sort_cyc++;
                if (n_done == 0 && err_s != 2'b00) err_early = 1'b1;
            end
            check("wdog_sort_cycles", sort_cyc, 256);
            check("wdog_err_early", err_early, 0);
            check("wdog_err", err_s, 2'b01);
            check("wdog_job_done", done_seen, 2'b01);
            check("wdog_no_m_tvalid", mv_any, 0);
            eng_hang = 1'b0;
            cycle();
            check("wdog_err_sticky", err_s, 2'b01);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qsort_arb.md
QSORT_ARB -- requirements
Module: qsort_arb

Interface
REQ-001 Parameters SHALL be: pDATA_WIDTH, 32, stream word width; pN, 10, words per sort job (2..15).
REQ-002 axis_clk  in  1  single clock; all logic on rising edge.
REQ-003 axis_rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  2  per-requester job request level; bit r = requester r.
REQ-005 gnt  out  2  one-hot grant; 0 when idle.
REQ-006 job_done  out  2  one-cycle pulse on the granted bit at job end.
REQ-007 s_tvalid / s_tready  in / out  2 / 2  per-requester input stream handshake.
REQ-008 s_tdata  in  2*pDATA_WIDTH  input data; requester r at bits [r*pDATA_WIDTH +: pDATA_WIDTH].
REQ-009 m_tvalid / m_tready  out / in  2 / 2  per-requester sorted output stream handshake.
REQ-010 m_tdata  out  2*pDATA_WIDTH  sorted output data, same packing as s_tdata.
REQ-011 eng_start  out  1  one-cycle start pulse to the sort engine.
REQ-012 eng_clr  out  1  one-cycle engine clear, active-high, asserted between jobs.
REQ-013 eng_ss_tvalid, eng_ss_tdata / eng_ss_tready  out, out / in  1, pDATA_WIDTH / 1  engine input stream.
REQ-014 eng_sm_tvalid, eng_sm_tdata / eng_sm_tready  in, in / out  1, pDATA_WIDTH / 1  engine output stream.
REQ-015 eng_done  in  1  engine sort-complete level.
REQ-016 err  out  2  sticky per-requester timeout flag.

Function
REQ-017 FSM SHALL have states IDLE, START, LOAD, SORT, DRAIN, CLEAR.
REQ-018 IDLE: with any req bit set, next cycle SHALL enter START with gnt set to the winner.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset requester 0 has priority.
REQ-020 req SHALL be sampled only in IDLE; dropping req mid-job SHALL NOT abort the job.
REQ-021 START: eng_start=1 for exactly one cycle, then LOAD.
REQ-022 LOAD: eng_ss_tvalid=s_tvalid[g], eng_ss_tdata=granted slice, s_tready[g]=eng_ss_tready; a word counts when valid and ready are both high.
REQ-023 After the pN-th counted input word, s_tready and eng_ss_tvalid SHALL be 0 from the next cycle; state SHALL go to SORT.
REQ-024 SORT: wait for eng_done=1, then DRAIN.
REQ-025 DRAIN: m_tvalid[g]=eng_sm_tvalid, m_tdata slice g=eng_sm_tdata, eng_sm_tready=m_tready[g]; handshakes SHALL be counted.
REQ-026 After the pN-th output handshake, m_tvalid and eng_sm_tready SHALL be 0 from the next cycle, even if eng_sm_tvalid stays high; state SHALL go to CLEAR.
REQ-027 CLEAR: eng_clr=1 and job_done[g]=1 for one cycle; gnt clears; state SHALL go to IDLE; last-granted pointer SHALL update.
REQ-028 Non-granted requester streams SHALL see s_tready=0, m_tvalid=0, m_tdata slice=0 at all times.
REQ-029 Word counter width SHALL be 4 bits, cleared on START and on entry to DRAIN; it SHALL never exceed pN.
REQ-030 Back-to-back jobs: a new grant SHALL NOT be issued earlier than the cycle after CLEAR.

Reset
REQ-031 On axis_rst=1, state SHALL be IDLE immediately; counters 0; pointer favours requester 0; err=0.
REQ-032 All outputs SHALL be 0 in reset: gnt, job_done, s_tready, m_tvalid, m_tdata, eng_start, eng_ss_tvalid, eng_ss_tdata, eng_sm_tready.
REQ-033 eng_clr SHALL be 1 while axis_rst=1 and 0 from the first post-reset edge, so reset mid-job also clears the engine.

Configuration
REQ-034 With QSORT_ARB_TIMEOUT_EN defined, an 8-bit SORT watchdog SHALL run; 255 cycles in SORT without eng_done SHALL set err[g], skip DRAIN and go to CLEAR.
REQ-035 The watchdog timeout SHALL assert job_done[g] in CLEAR as normal.
REQ-036 Without QSORT_ARB_TIMEOUT_EN, err SHALL be constant 0 and SORT SHALL wait indefinitely.

Verification
REQ-037 req=01, feed 10 words 9..0 with valid always high -> one eng_start pulse; m0 emits 0..9; one job_done[0] pulse; eng_clr pulse; gnt returns to 00.
REQ-038 req=11 held for two jobs -> grants 01 then 10; second job uses stream 1 only; s_tready[1]=0 during job 0.
REQ-039 m_tready[0] toggled 1,0,1,0... during DRAIN -> exactly 10 output words, no duplicates or loss; m_tvalid[0]=0 after the 10th word while eng_sm_tvalid=1.
REQ-040 axis_rst asserted after 5 words are loaded -> all outputs 0, eng_clr=1; after release, req=01 job completes correctly.
REQ-041 QSORT_ARB_TIMEOUT_EN defined, eng_done held 0 -> err[0]=1 on cycle 255 of SORT; job_done[0] pulses; m_tvalid[0] never 1.
REQ-042 req=10 dropped to 00 during LOAD -> job still completes with 10 outputs and job_done=10.
